// File: rtl/mmio_perf_counters_pkg.sv
// Shared constants for the memory-mapped performance counter block.
// Control offsets are relative to the control base, which sits at 4*NUM_CNT.
package mmio_perf_pkg;

  localparam int unsigned MAX_CNT = 8;

  localparam logic [31:0] ENABLE_OFS   = 32'h0;
  localparam logic [31:0] CLEAR_OFS    = 32'h4;
  localparam logic [31:0] OVF_OFS      = 32'h8;
  localparam logic [31:0] SNAP_OFS     = 32'hC;
  localparam logic [31:0] SNAPBASE_OFS = 32'h40;

  // Byte offset from BASE_ADDR of a control register for a given counter count.
  function automatic logic [31:0] ctrl_ofs(input int unsigned num_cnt, input logic [31:0] rel);
    return 32'(4 * num_cnt) + rel;
  endfunction

endpackage

// File: rtl/mmio_perf_counters_if.sv
// CPU memory-stage access port for the performance counter block.
interface mmio_perf_counters_if;
  // we/re are single-cycle strobes, one access per cycle; there is no stall.
  // A load presents rdata on the cycle after re and holds it until the next re.
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/mmio_perf_counters_slice.sv
// One event counter: counts gated events, clears synchronously, wraps silently
// and reports the wrap as a one-cycle overflow pulse.
module perf_counter_slice #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 en,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf_pulse
);

  logic bump;

  // A clear suppresses both the increment and the overflow it would cause.
  assign bump      = inc & en & ~clr;
  assign ovf_pulse = bump & (&count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (bump) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_perf_counters.sv
// Memory-mapped bank of event counters with enable mask, clear, sticky
// overflow flags and a snapshot bank, readable over a one-cycle-latency port.
module mmio_perf_counters
  import mmio_perf_pkg::*;
#(
  parameter int unsigned NUM_CNT   = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_perf_counters_if.slave  bus,
  input  logic [NUM_CNT-1:0]   inc
);

  localparam logic [31:0] ENABLE_ADDR = ctrl_ofs(NUM_CNT, ENABLE_OFS);
  localparam logic [31:0] CLEAR_ADDR  = ctrl_ofs(NUM_CNT, CLEAR_OFS);
  localparam logic [31:0] OVF_ADDR    = ctrl_ofs(NUM_CNT, OVF_OFS);
  localparam logic [31:0] SNAP_ADDR   = ctrl_ofs(NUM_CNT, SNAP_OFS);

  logic [31:0]          ofs;
  logic                 wr_enable;
  logic                 wr_clear;
  logic                 wr_ovf;
  logic                 wr_snap;
  logic [NUM_CNT-1:0]   wmask;
  logic [NUM_CNT-1:0]   clr_mask;
  logic [NUM_CNT-1:0]   enable_q;
  logic [NUM_CNT-1:0]   ovf_q;
  logic [NUM_CNT-1:0]   ovf_pulse;
  logic [CNT_WIDTH-1:0] cnt    [NUM_CNT];
  logic [CNT_WIDTH-1:0] snap_q [NUM_CNT];
  logic [31:0]          rd_next;
  logic [31:0]          rdata_q;
  logic                 unused_wdata;

  // Misaligned addresses never match an aligned register offset, so they fall
  // through to the unmapped case.
  assign ofs       = bus.addr - BASE_ADDR;
  assign wmask     = bus.wdata[NUM_CNT-1:0];
  assign wr_enable = bus.we && (ofs == ENABLE_ADDR);
  assign wr_clear  = bus.we && (ofs == CLEAR_ADDR);
  assign wr_ovf    = bus.we && (ofs == OVF_ADDR);
  assign wr_snap   = bus.we && (ofs == SNAP_ADDR);
  assign clr_mask  = wr_clear ? wmask : '0;

  assign unused_wdata = ^bus.wdata;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_slice
    perf_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc[g]),
      .en        (enable_q[g]),
      .clr       (clr_mask[g]),
      .count     (cnt[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '1;
    end else if (wr_enable) begin
      enable_q <= wmask;
    end
  end

  // A fresh overflow on the same edge as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~(wr_ovf ? wmask : '0)) | ovf_pulse;
    end
  end

  // Snapshots take the registered counts, i.e. the values before this edge's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= '0;
      end
    end else if (wr_snap) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= cnt[i];
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (ofs == 32'(4 * i)) begin
        rd_next[CNT_WIDTH-1:0] = cnt[i];
      end
      if (ofs == SNAPBASE_OFS + 32'(4 * i)) begin
        rd_next[CNT_WIDTH-1:0] = snap_q[i];
      end
    end
    if (ofs == ENABLE_ADDR) begin
      rd_next[NUM_CNT-1:0] = enable_q;
    end
    if (ofs == OVF_ADDR) begin
      rd_next[NUM_CNT-1:0] = ovf_q;
    end
  end

  // Sampled from pre-edge state, so a coincident store is not visible yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (bus.re) begin
      rdata_q <= rd_next;
    end
  end

  assign bus.rdata = rdata_q;

endmodule
